// File: rtl/pc_sequencer_pkg.sv
// Shared pc_seq_defs definitions for the next-PC sequencer: state encodings,
// instruction size and the default reset / halt / trap addresses.
package pc_sequencer_pkg;

  // 3-bit FSM encoding of the sequencer
  typedef enum logic [2:0] {
    ST_BOOT  = 3'd0,
    ST_RUN   = 3'd1,
    ST_PEND  = 3'd2,
    ST_FLUSH = 3'd3,
    ST_HALT  = 3'd4
  } state_e;

  localparam logic [31:0] INSN_BYTES    = 32'd4;
  localparam logic [31:0] DEF_RESET_VEC = 32'h0000_0000;
  localparam logic [31:0] DEF_HALT_ADDR = 32'd248;
  localparam logic [31:0] DEF_TRAP_VEC  = 32'h0000_0100;

  // Saturating 16-bit increment for the redirect counter
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/pc_sequencer_next_mux.sv
// pc_next_mux: combinational selection of the redirect target (jump beats
// branch, or the held pending target) and the sequential address, plus the
// alignment fix-up. With MISALIGN_TRAP_EN defined a misaligned target is
// replaced by TRAP_VEC and flagged; otherwise the low two bits are cleared.
module pc_next_mux
  import pc_sequencer_pkg::*;
#(
`ifdef MISALIGN_TRAP_EN
  parameter logic [31:0] TRAP_VEC = DEF_TRAP_VEC
`endif
) (
  input  logic [31:0] pc_cur_i,
  input  logic        branch_i,
  input  logic [31:0] branch_target_i,
  input  logic        jump_i,
  input  logic [31:0] jump_target_i,
  input  logic        use_pend_i,
  input  logic [31:0] pend_tgt_i,
  output logic        redir_o,
  output logic [31:0] tgt_raw_o,
  output logic [31:0] tgt_fix_o,
  output logic        trap_o,
  output logic [31:0] seq_addr_o
);

  logic [31:0] src;

  // Redirect source selection and sequential address (wraps modulo 2^32)
  always_comb begin
    redir_o    = jump_i | branch_i;
    tgt_raw_o  = jump_i ? jump_target_i : branch_target_i;
    src        = use_pend_i ? pend_tgt_i : tgt_raw_o;
    seq_addr_o = pc_cur_i + INSN_BYTES;
  end

`ifdef MISALIGN_TRAP_EN
  // Misaligned targets are diverted to the trap vector
  always_comb begin
    trap_o    = (src[1:0] != 2'b00);
    tgt_fix_o = trap_o ? TRAP_VEC : src;
  end
`else
  // Misaligned targets are silently word-aligned
  always_comb begin
    trap_o    = 1'b0;
    tgt_fix_o = src & ~32'h0000_0003;
  end
`endif

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: next-PC controller for the fetch stage. Chooses the next PC,
// freezes the PC on stalls, parks redirects that arrive during a stall,
// drives the IF/ID flush and sequences the halt state.
// Optional feature macro: MISALIGN_TRAP_EN (trap misaligned redirect targets).
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter logic [31:0] RESET_VEC    = DEF_RESET_VEC,
  parameter logic [31:0] HALT_ADDR    = DEF_HALT_ADDR,
  parameter int unsigned FLUSH_CYCLES = 1
`ifdef MISALIGN_TRAP_EN
  , parameter logic [31:0] TRAP_VEC   = DEF_TRAP_VEC
`endif
) (
  input  logic        clk_i,
  input  logic        start_i,
  input  logic [31:0] pc_cur_i,
  input  logic        hazard_i,
  input  logic        branch_i,
  input  logic [31:0] branch_target_i,
  input  logic        jump_i,
  input  logic [31:0] jump_target_i,
  output logic [31:0] pc_next_o,
  output logic        pc_hold_o,
  output logic        flush_o,
  output logic        halted_o,
  output logic        misalign_o,
  output logic [15:0] redirect_cnt_o
);

  localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_CYCLES);

  state_e      state_q, state_d;
  logic [31:0] pend_q, pend_d;
  logic [2:0]  flush_cnt_q, flush_cnt_d;
  logic [15:0] cnt_q, cnt_d;
  logic        flush_q, halted_q, misalign_q;
  logic        trap_d;
  logic        apply;

  logic        redir;
  logic [31:0] tgt_raw, tgt_fix, seq_addr;
  logic        trap;
  logic        use_pend;

  assign use_pend = (state_q == ST_PEND);

  pc_next_mux
`ifdef MISALIGN_TRAP_EN
    #(.TRAP_VEC(TRAP_VEC))
`endif
  u_mux (
    .pc_cur_i        (pc_cur_i),
    .branch_i        (branch_i),
    .branch_target_i (branch_target_i),
    .jump_i          (jump_i),
    .jump_target_i   (jump_target_i),
    .use_pend_i      (use_pend),
    .pend_tgt_i      (pend_q),
    .redir_o         (redir),
    .tgt_raw_o       (tgt_raw),
    .tgt_fix_o       (tgt_fix),
    .trap_o          (trap),
    .seq_addr_o      (seq_addr)
  );

  // Next-state, next-PC and hold decode
  always_comb begin
    state_d     = state_q;
    pend_d      = pend_q;
    flush_cnt_d = flush_cnt_q;
    cnt_d       = cnt_q;
    trap_d      = 1'b0;
    apply       = 1'b0;
    pc_next_o   = pc_cur_i;
    pc_hold_o   = 1'b1;

    case (state_q)
      ST_BOOT: begin
        pc_next_o = RESET_VEC;
        pc_hold_o = 1'b1;
        state_d   = ST_RUN;
      end

      ST_RUN: begin
        if (redir && !hazard_i) begin
          pc_next_o = tgt_fix;
          pc_hold_o = 1'b0;
          apply     = 1'b1;
        end else if (redir) begin
          // Park the raw target; the fix-up happens when it is applied
          pend_d    = tgt_raw;
          pc_next_o = pc_cur_i;
          pc_hold_o = 1'b1;
          state_d   = ST_PEND;
        end else if (pc_cur_i == HALT_ADDR) begin
          pc_next_o = HALT_ADDR;
          pc_hold_o = 1'b0;
          state_d   = ST_HALT;
        end else if (hazard_i) begin
          pc_next_o = pc_cur_i;
          pc_hold_o = 1'b1;
        end else begin
          pc_next_o = seq_addr;
          pc_hold_o = 1'b0;
        end
      end

      ST_PEND: begin
        if (hazard_i) begin
          pc_next_o = pc_cur_i;
          pc_hold_o = 1'b1;
        end else begin
          pc_next_o = tgt_fix;
          pc_hold_o = 1'b0;
          apply     = 1'b1;
        end
      end

      ST_FLUSH: begin
        // Redirects here come from squashed instructions and are ignored
        flush_cnt_d = (flush_cnt_q > 3'd0) ? flush_cnt_q - 3'd1 : 3'd0;
        state_d     = (flush_cnt_d == 3'd0) ? ST_RUN : ST_FLUSH;
        if (pc_cur_i == HALT_ADDR) begin
          pc_next_o   = HALT_ADDR;
          pc_hold_o   = 1'b0;
          flush_cnt_d = 3'd0;
          state_d     = ST_HALT;
        end else if (hazard_i) begin
          pc_next_o = pc_cur_i;
          pc_hold_o = 1'b1;
        end else begin
          pc_next_o = seq_addr;
          pc_hold_o = 1'b0;
        end
      end

      ST_HALT: begin
        pc_next_o = HALT_ADDR;
        pc_hold_o = 1'b1;
      end

      default: begin
        state_d = ST_BOOT;
      end
    endcase

    // Common bookkeeping for an applied redirect
    if (apply) begin
      cnt_d       = sat_inc16(cnt_q);
      flush_cnt_d = FLUSH_INIT;
      trap_d      = trap;
      state_d     = ST_FLUSH;
    end
  end

  // State and registered-output update with asynchronous active-low reset
  always_ff @(posedge clk_i or negedge start_i) begin
    if (!start_i) begin
      state_q     <= ST_BOOT;
      pend_q      <= 32'h0;
      flush_cnt_q <= 3'd0;
      cnt_q       <= 16'h0;
      flush_q     <= 1'b0;
      halted_q    <= 1'b0;
      misalign_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      pend_q      <= pend_d;
      flush_cnt_q <= flush_cnt_d;
      cnt_q       <= cnt_d;
      flush_q     <= (flush_cnt_d != 3'd0);
      halted_q    <= (state_d == ST_HALT);
      // trap is constant 0 without the trap feature, so this stays low
      misalign_q  <= trap_d;
    end
  end

  assign flush_o        = flush_q;
  assign halted_o       = halted_q;
  assign misalign_o     = misalign_q;
  assign redirect_cnt_o = cnt_q;

endmodule
